// File: rtl/opb_register_ppc2simulink_sync.sv
// ---------------------------------------------------------------------------
// opb_register_ppc2simulink_sync
//
// OPB slave that holds one 32-bit software-writable register. The PPC writes
// it over OPB, and user fabric logic sees it as a parallel word plus a
// one-cycle update strobe. User logic shares OPB_Clk, so there is no clock
// crossing. Word 0 (offset 0x0) is the register, which can also be read back.
//
// Optional build macro: OPB_P2S_WRCNT_EN
//   defined   : word 1 (offset 0x4) is a 32-bit count of word-0 writes that
//               have at least one byte enable set. Any write to word 1
//               clears the count.
//   undefined : word 1 reads as zero. Writes to it are acked and ignored.
//
// Ports
//   OPB_Clk, OPB_Rst    clock and synchronous active-high reset
//   OPB_ABus [0:31]     address (bit 0 is the MSB)
//   OPB_BE   [0:3]      byte enables; BE[0] covers DBus[0:7]
//   OPB_DBus [0:31]     write data (bit 0 is the MSB)
//   OPB_RNW             1 = read, 0 = write
//   OPB_select          transfer in progress
//   OPB_seqAddr         ignored
//   Sl_DBus  [0:31]     read data; zero except in the ack cycle of a read
//   Sl_errAck, Sl_retry, Sl_toutSup   always 0
//   Sl_xferAck          one-cycle transfer acknowledge
//   user_data_out[31:0] register value; bit 31 corresponds to DBus[0]
//   user_data_valid     one-cycle pulse in the cycle after a register update
// ---------------------------------------------------------------------------
module opb_register_ppc2simulink_sync #(
  parameter logic [31:0] C_BASEADDR   = 32'h01080A00,
  parameter logic [31:0] C_HIGHADDR   = 32'h01080AFF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter logic [31:0] C_INIT       = 32'h00000000
) (
  input  logic                      OPB_Clk,
  input  logic                      OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
  input  logic [0:C_OPB_DWIDTH/8-1] OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
  input  logic                      OPB_RNW,
  input  logic                      OPB_select,
  input  logic                      OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
  output logic                      Sl_errAck,
  output logic                      Sl_retry,
  output logic                      Sl_toutSup,
  output logic                      Sl_xferAck,
  output logic [31:0]               user_data_out,
  output logic                      user_data_valid
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACK,
    ST_WAIT
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] reg_q, reg_d;
  logic        valid_q, valid_d;

  logic        hit;
  logic        ack;
  logic        word_sel;
  logic [31:0] wr_data;
  logic [31:0] word1_value;
  logic [31:0] rd_word;
  logic        unused_ok;

  // Sequential-burst hinting has no meaning for a single-register slave.
  assign unused_ok = OPB_seqAddr;

  // The address decode covers the whole window. ABus[29] selects between
  // even words (the register) and odd words (word 1), so each word repeats
  // throughout the range.
  assign hit      = OPB_select && (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
  assign word_sel = OPB_ABus[29];
  assign ack      = (state_q == ST_ACK);

  // Assigning the big-endian bus to a little-endian vector maps DBus[0] to
  // bit 31, so the byte lanes line up with user_data_out without swapping.
  assign wr_data  = OPB_DBus;

  // The ACK state is entered unconditionally from a hit and lasts exactly
  // one cycle. WAIT absorbs a select that is held after the ack, so a long
  // select cannot produce a second ack.
  always_comb begin
    state_d = state_q;
    reg_d   = reg_q;
    valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (hit) begin
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        state_d = ST_WAIT;
        if (!OPB_RNW && !word_sel) begin
          for (int i = 0; i < 4; i++) begin
            if (OPB_BE[i]) begin
              reg_d[31-8*i -: 8] = wr_data[31-8*i -: 8];
            end
          end
          // Any enabled lane counts as an update, even if the data is
          // unchanged. An all-zero BE write is acked silently.
          valid_d = |OPB_BE;
        end
      end
      ST_WAIT: begin
        if (!OPB_select) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      state_q <= ST_IDLE;
      reg_q   <= C_INIT;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      reg_q   <= reg_d;
      valid_q <= valid_d;
    end
  end

`ifdef OPB_P2S_WRCNT_EN
  logic [31:0] wr_cnt_q, wr_cnt_d;
  logic        cnt_inc;
  logic        cnt_clr;

  // The count advances on the same edge that updates the register. A
  // clear from a word-1 write takes priority.
  assign cnt_inc = ack && !OPB_RNW && !word_sel && (|OPB_BE);
  assign cnt_clr = ack && !OPB_RNW && word_sel;

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    if (cnt_inc) begin
      wr_cnt_d = wr_cnt_q + 32'd1;
    end
    if (cnt_clr) begin
      wr_cnt_d = 32'd0;
    end
  end

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      wr_cnt_q <= 32'd0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign word1_value = wr_cnt_q;
`else
  assign word1_value = 32'd0;
`endif

  assign rd_word = word_sel ? word1_value : reg_q;

  // The OPB read bus is wired-OR across slaves, so it must stay zero except
  // during this slave's read ack.
  assign Sl_DBus         = (ack && OPB_RNW) ? rd_word : '0;
  assign Sl_xferAck      = ack;
  assign Sl_errAck       = 1'b0;
  assign Sl_retry        = 1'b0;
  assign Sl_toutSup      = 1'b0;
  assign user_data_out   = reg_q;
  assign user_data_valid = valid_q;

endmodule

// File: tb/tb_opb_register_ppc2simulink_sync.sv
// ---------------------------------------------------------------------------
// tb_opb_register_ppc2simulink_sync
//
// Scoreboard testbench for opb_register_ppc2simulink_sync. Each transfer
// pushes its expected ack data, and any expected user update, onto queues.
// A monitor pops and compares these whenever the DUT raises Sl_xferAck or
// user_data_valid. Build with +define+OPB_P2S_WRCNT_EN to exercise the
// write counter on word 1.
// ---------------------------------------------------------------------------
module tb_opb_register_ppc2simulink_sync;

  localparam logic [31:0] INIT = 32'hDEADBEEF;
  localparam logic [31:0] BASE = 32'h01080A00;

  logic        clk = 1'b0;
  logic        rst;
  logic [0:31] abus;
  logic [0:3]  be;
  logic [0:31] dbus;
  logic        rnw;
  logic        sel;
  logic        seqAddr;
  logic [0:31] slDBus;
  logic        slErrAck;
  logic        slRetry;
  logic        slToutSup;
  logic        slXferAck;
  logic [31:0] userData;
  logic        userValid;

  int          vecCount  = 0;
  int          missCount = 0;
  bit          monitorOn = 1'b0;
  logic [31:0] ackQ[$];
  logic [31:0] validQ[$];

  always #5 clk = ~clk;

  opb_register_ppc2simulink_sync #(
    .C_BASEADDR  (32'h01080A00),
    .C_HIGHADDR  (32'h01080AFF),
    .C_OPB_AWIDTH(32),
    .C_OPB_DWIDTH(32),
    .C_INIT      (INIT)
  ) dut (
    .OPB_Clk        (clk),
    .OPB_Rst        (rst),
    .OPB_ABus       (abus),
    .OPB_BE         (be),
    .OPB_DBus       (dbus),
    .OPB_RNW        (rnw),
    .OPB_select     (sel),
    .OPB_seqAddr    (seqAddr),
    .Sl_DBus        (slDBus),
    .Sl_errAck      (slErrAck),
    .Sl_retry       (slRetry),
    .Sl_toutSup     (slToutSup),
    .Sl_xferAck     (slXferAck),
    .user_data_out  (userData),
    .user_data_valid(userValid)
  );

  // Single comparison point: every check increments the vector count, and
  // every miscompare increments the failure count.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // The monitor samples 2 time units after each rising edge. Acks and valid
  // pulses are matched against the queues, and the read bus must be idle
  // whenever no ack is present.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (monitorOn) begin
        if (slXferAck === 1'b1) begin
          if (ackQ.size() == 0) begin
            checkOutput("unexpected_ack", {31'b0, slXferAck}, 32'd0);
          end else begin
            checkOutput("ack_rdata", slDBus, ackQ.pop_front());
          end
        end else begin
          checkOutput("idle_dbus", slDBus, 32'd0);
        end
        if (userValid === 1'b1) begin
          if (validQ.size() == 0) begin
            checkOutput("unexpected_valid", {31'b0, userValid}, 32'd0);
          end else begin
            checkOutput("user_data", userData, validQ.pop_front());
          end
        end
      end
    end
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("[TB] FAIL watchdog: simulation exceeded 20000 cycles");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic busIdle();
    sel  = 1'b0;
    abus = '0;
    be   = '0;
    dbus = '0;
    rnw  = 1'b0;
  endtask

  // Runs one OPB transfer. With hold == 0, select drops after the ack has
  // been seen and the ack must arrive in the second cycle of select. With
  // hold > 0, select is held for that many cycles regardless of any ack.
  task automatic applyStimulus(input logic [31:0] addr, input logic rnwIn, input logic [3:0] beIn,
                               input logic [31:0] wdata, input bit expAck, input logic [31:0] expRd,
                               input bit expPulse, input logic [31:0] expVal, input int hold);
    int lat;
    bit seen;
    if (expAck) ackQ.push_back(rnwIn ? expRd : 32'd0);
    if (expPulse) validQ.push_back(expVal);
    @(posedge clk);
    #1;
    sel  = 1'b1;
    abus = addr;
    be   = beIn;
    dbus = wdata;
    rnw  = rnwIn;
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1;
      busIdle();
    end else begin
      lat  = 0;
      seen = 1'b0;
      for (int i = 1; i <= 8 && !seen; i++) begin
        @(posedge clk);
        #2;
        if (slXferAck === 1'b1) begin
          seen = 1'b1;
          lat  = i;
        end
      end
      checkOutput("ack_latency", lat, 32'd1);
      @(posedge clk);
      #1;
      busIdle();
    end
  endtask

  task automatic opbWrite(input logic [31:0] addr, input logic [3:0] beIn, input logic [31:0] wdata,
                          input bit expPulse, input logic [31:0] expVal);
    applyStimulus(addr, 1'b0, beIn, wdata, 1'b1, 32'd0, expPulse, expVal, 0);
  endtask

  task automatic opbRead(input logic [31:0] addr, input logic [31:0] expRd);
    applyStimulus(addr, 1'b1, 4'hF, 32'd0, 1'b1, expRd, 1'b0, 32'd0, 0);
  endtask

  task automatic checkUser(input string name, input logic [31:0] expected);
    @(posedge clk);
    #2;
    checkOutput(name, userData, expected);
  endtask

  initial begin
    rst     = 1'b1;
    seqAddr = 1'b0;
    busIdle();
    repeat (3) @(posedge clk);
    #2;
    checkOutput("reset_user_data", userData, INIT);
    checkOutput("reset_xferack", {31'b0, slXferAck}, 32'd0);
    checkOutput("reset_dbus", slDBus, 32'd0);
    checkOutput("reset_valid", {31'b0, userValid}, 32'd0);
    checkOutput("tieoffs", {29'b0, slErrAck, slRetry, slToutSup}, 32'd0);
    rst = 1'b0;
    monitorOn = 1'b1;

    // Full write, then read it back.
    opbWrite(BASE, 4'b1111, 32'h12345678, 1'b1, 32'h12345678);
    checkUser("after_full_write", 32'h12345678);
    opbRead(BASE, 32'h12345678);

    // Partial write using lanes 1 and 3 only.
    opbWrite(BASE, 4'b0101, 32'hAABBCCDD, 1'b1, 32'h12BB56DD);
    checkUser("after_partial_write", 32'h12BB56DD);

    // A zero byte-enable write is acked but causes no update and no pulse.
    opbWrite(BASE, 4'b0000, 32'hFFFFFFFF, 1'b0, 32'd0);
    checkUser("after_be0_write", 32'h12BB56DD);

    // Rewriting the same value still produces a pulse.
    opbWrite(BASE, 4'b1111, 32'h12BB56DD, 1'b1, 32'h12BB56DD);

    // Word 0 aliases at even words, and low address bits are ignored.
    opbRead(BASE + 32'h8, 32'h12BB56DD);
    opbRead(BASE + 32'h3, 32'h12BB56DD);

    // Select held for 6 cycles must produce a single ack.
    applyStimulus(BASE, 1'b1, 4'hF, 32'd0, 1'b1, 32'h12BB56DD, 1'b0, 32'd0, 6);

    // Addresses outside the window are never acked.
    applyStimulus(32'h01080B00, 1'b0, 4'hF, 32'h0BADF00D, 1'b0, 32'd0, 1'b0, 32'd0, 4);
    applyStimulus(32'h010809FC, 1'b1, 4'hF, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 4);
    checkUser("after_out_of_range", 32'h12BB56DD);

`ifdef OPB_P2S_WRCNT_EN
    opbWrite(BASE + 32'h4, 4'hF, 32'd0, 1'b0, 32'd0);
    opbRead(BASE + 32'h4, 32'd0);
    opbWrite(BASE, 4'b1111, 32'h11111111, 1'b1, 32'h11111111);
    opbWrite(BASE, 4'b1000, 32'h22222222, 1'b1, 32'h22111111);
    opbWrite(BASE, 4'b0001, 32'h33333333, 1'b1, 32'h22111133);
    opbWrite(BASE, 4'b0000, 32'h44444444, 1'b0, 32'd0);
    opbRead(BASE + 32'h4, 32'd3);
    opbWrite(BASE + 32'hC, 4'hF, 32'h5A5A5A5A, 1'b0, 32'd0);
    opbRead(BASE + 32'h4, 32'd0);
    @(posedge clk);
    #1;
    force dut.wr_cnt_q = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    release dut.wr_cnt_q;
    opbRead(BASE + 32'h4, 32'hFFFFFFFF);
    opbWrite(BASE, 4'b1111, 32'h44444444, 1'b1, 32'h44444444);
    opbRead(BASE + 32'h4, 32'd0);
    opbRead(BASE, 32'h44444444);
`else
    // Without the counter, word 1 reads as zero, and writes to it are
    // acked with no effect.
    opbRead(BASE + 32'h4, 32'd0);
    opbWrite(BASE + 32'h4, 4'hF, 32'hCAFEF00D, 1'b0, 32'd0);
    opbRead(BASE + 32'hC, 32'd0);
    checkUser("after_word1_write", 32'h12BB56DD);
`endif

    // Reset on the edge that would enter ACK aborts the transfer.
    @(posedge clk);
    #1;
    rst  = 1'b1;
    sel  = 1'b1;
    abus = BASE;
    be   = 4'hF;
    dbus = 32'h55555555;
    rnw  = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    busIdle();
    repeat (2) @(posedge clk);
    #2;
    checkOutput("after_reset_abort", userData, INIT);
    opbRead(BASE, INIT);

    repeat (3) @(posedge clk);
    #2;
    checkOutput("ack_queue_left", ackQ.size(), 32'd0);
    checkOutput("valid_queue_left", validQ.size(), 32'd0);
    monitorOn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/opb_register_ppc2simulink_sync.md
Name: opb_register_ppc2simulink_sync

Overview:
OPB slave holding one 32-bit software-writable register, presented to user fabric logic as a parallel output plus a one-cycle update strobe. This is the PPC-to-fabric counterpart of the fabric-to-PPC status register blocks in the design's OPB address map. User logic runs on OPB_Clk, so no clock-domain crossing is needed. The PPC can read the register back at offset 0x0.

Parameters:
C_BASEADDR, 32'h01080A00, first byte address decoded by this slave.
C_HIGHADDR, 32'h01080AFF, last byte address decoded by this slave.
C_OPB_AWIDTH, 32, OPB address width.
C_OPB_DWIDTH, 32, OPB data width; only 32 is supported.
C_INIT, 32'h00000000, reset value of the register.

Ports:
OPB_Clk  in  1  single clock for bus and user side.
OPB_Rst  in  1  reset, synchronous, active-high.
OPB_ABus  in  [0:31]  address, bit 0 MSB.
OPB_BE  in  [0:3]  byte enables; BE[0] covers DBus[0:7].
OPB_DBus  in  [0:31]  write data, bit 0 MSB.
OPB_RNW  in  1  1=read, 0=write.
OPB_select  in  1  transfer in progress.
OPB_seqAddr  in  1  ignored.
Sl_DBus  out  [0:31]  read data; zero when not acking.
Sl_errAck  out  1  tied 0.
Sl_retry  out  1  tied 0.
Sl_toutSup  out  1  tied 0.
Sl_xferAck  out  1  one-cycle transfer acknowledge.
user_data_out  out  [31:0]  register value; user bit 31 = DBus[0].
user_data_valid  out  1  one-cycle pulse after each register update.

Behaviour:
- Reset (OPB_Rst=1 at edge): register=C_INIT, FSM=IDLE, Sl_xferAck=0, Sl_DBus=0, user_data_valid=0, counter=0. Reset during an active transfer aborts it: no ack and no register update.
- hit = OPB_select & (C_BASEADDR <= OPB_ABus <= C_HIGHADDR). Word select = OPB_ABus[29]; ABus[30:31] ignored. Word 1 repeats at every odd word in range; word 0 at every even word.
- FSM states:
  - IDLE: on hit, go to ACK.
  - ACK: Sl_xferAck=1 for exactly this cycle; perform the read or write; go to WAIT.
  - WAIT: stay while OPB_select=1; go to IDLE when OPB_select=0. This prevents a double ack on a held select.
- Latency: ack is asserted in the 2nd cycle of select; address, BE and data are sampled in the ACK cycle.
- Read: in the ACK cycle, Sl_DBus = word value in OPB bit order. Sl_DBus=0 in all other cycles (OR-bus rule).
- Write to word 0, ACK cycle: each lane with BE set updates its byte (BE[0]->bits 31:24 ... BE[3]->7:0).
  - New value is visible on user_data_out in the following cycle; user_data_valid=1 for exactly that cycle.
  - BE=4'b0000: transfer is acked, register is unchanged, no valid pulse.
  - Writing the same value still produces a valid pulse.
- Address outside range: never acked; outputs unchanged.

Optional Feature:
Macro OPB_P2S_WRCNT_EN.
- Defined: word 1 (offset 0x4) is a 32-bit count of word-0 writes with nonzero BE. It increments in the same cycle as the register update and wraps 0xFFFFFFFF->0. Any write to word 1 clears the count to 0; if the clear coincides with an increment, clear wins.
- Undefined: word 1 reads return 0; writes are acked and ignored; no counter logic is built.

Test Plan:
- Reset with C_INIT=32'hDEADBEEF -> user_data_out=0xDEADBEEF, Sl_xferAck=0, Sl_DBus=0, user_data_valid=0.
- Write 0x12345678 to 0x01080A00, BE=1111 -> ack in 2nd select cycle; next cycle user_data_out=0x12345678 with valid=1 for one cycle; read back of 0x0 returns 0x12345678 with Sl_DBus=0 outside the ack cycle.
- Then write 0xAABBCCDD with BE=0101 -> user_data_out=0x12BB56DD, one valid pulse. Write with BE=0000 -> ack, value unchanged, no pulse.
- Hold OPB_select high for 6 cycles on a hit -> exactly one ack. Access 0x01080B00 -> no ack. Assert OPB_Rst in the ACK-entry cycle -> no ack, register=C_INIT.
- With OPB_P2S_WRCNT_EN: 3 nonzero-BE writes plus 1 BE=0 write -> read 0x4 returns 3. Write to 0x4 -> next read returns 0. Preload count 0xFFFFFFFF, one write -> count 0.
- Without OPB_P2S_WRCNT_EN: read 0x4 returns 0 and is acked.
